sram_if_responder: RTL and testbench

//  Responder side of the async-SRAM-style ram_* interface (ram_a/ram_dq_i/ram_dq_o/cen/oen/wen/ub/lb).

---
 rtl/sram_if_pkg.sv | 25 ++
 rtl/sram_resp_mem.sv | 41 ++++
 rtl/sram_if_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_sram_if_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_if_pkg.sv
// Purpose : shared types and constants for the async-SRAM responder.
// Latency : n/a (package).
// Backpressure : n/a (package).
package sram_if_pkg;

    // Two byte lanes: lane 0 = [7:0] (lb), lane 1 = [15:8] (ub).
    localparam int LANE_W = 2;

    // Width of the wr/rd/abort statistics counters.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_HOLD = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    // The bus byte enables are active low; the array wants an active-high mask.
    function automatic logic [LANE_W-1:0] lane_mask(input logic ub, input logic lb);
        return {~ub, ~lb};
    endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Purpose : byte-laned word array, one lane-masked write port, one read port.
// Latency : write commits on the clock edge; read is combinational from rd_idx.
// Backpressure : none; accepts a write every cycle.
//
// Ports:
//   clk      clock
//   wr_en    commit wr_dat to wr_idx on the enabled lanes
//   wr_idx   write word index
//   wr_mask  per-lane write enable (active high)
//   wr_dat   write data
//   rd_idx   read word index
//   rd_dat   word at rd_idx
module sram_resp_mem #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LANES      = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [LANES-1:0]      wr_mask,
    input  logic [LANES*8-1:0]    wr_dat,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [LANES*8-1:0]    rd_dat
);

    // Contents deliberately have no reset: they must survive a responder reset.
    logic [LANES*8-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_dat[i*8 +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/sram_if_responder.sv
// Purpose : responder for the async-SRAM style ram_* bus, backed by an on-chip array.
// Latency : read data RD_LATENCY+1 edges after input capture; write commits WR_LATENCY+1 edges after capture.
// Backpressure : none on the bus; the initiator must hold controls stable for the latency (busy is advisory).
//
// Ports:
//   clk_in1, resetn             clock, synchronous active-low reset
//   ram_a, ram_dq_i             byte address (bit 0 ignored), write data
//   ram_dq_o                    read data, held until the next read completes
//   ram_cen/oen/wen/ub/lb       active-low chip/output/write/upper-byte/lower-byte enables
//   busy                        high while waiting out a read or write latency
//   wr_count/rd_count/abort_count  wrapping statistics counters
module sram_if_responder
    import sram_if_pkg::*;
#(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 16,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 4
) (
    input  logic              clk_in1,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] ram_a,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic [DATA_W-1:0] ram_dq_o,
    input  logic              ram_cen,
    input  logic              ram_oen,
    input  logic              ram_wen,
    input  logic              ram_ub,
    input  logic              ram_lb,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  abort_count
);

    localparam int IDX_W   = MEM_DEPTH_LOG2;
    localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int WAIT_W  = $clog2(LAT_MAX + 1);
    localparam logic [WAIT_W-1:0] RD_LAST = WAIT_W'(RD_LATENCY - 1);
    localparam logic [WAIT_W-1:0] WR_LAST = WAIT_W'(WR_LATENCY - 1);

    // Byte-select bit and the aliasing upper address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_a[ADDR_W-1:IDX_W+1], ram_a[0]};

    // ------------------------------------------------------------------
    // Input register stage: every bus signal is sampled once before use.
    // Reset parks the controls at their inactive level so the FSM sees an
    // idle bus on the first edge after reset.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] dq_q;
    logic              cen_q, oen_q, wen_q, ub_q, lb_q;

    always_ff @(posedge clk_in1) begin
        if (!resetn) begin
            idx_q <= '0;
            dq_q  <= '0;
            cen_q <= 1'b1;
            oen_q <= 1'b1;
            wen_q <= 1'b1;
            ub_q  <= 1'b1;
            lb_q  <= 1'b1;
        end else begin
            idx_q <= ram_a[IDX_W:1];
            dq_q  <= ram_dq_i;
            cen_q <= ram_cen;
            oen_q <= ram_oen;
            wen_q <= ram_wen;
            ub_q  <= ram_ub;
            lb_q  <= ram_lb;
        end
    end

    // ------------------------------------------------------------------
    // Latched access key (index + byte enables) and write data. Any change
    // of the live key against the latched one restarts the latency count.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  idx_l;
    logic [DATA_W-1:0] dat_l;
    logic              ub_l, lb_l;

    logic key_chg, dat_chg;
    assign key_chg = (idx_q != idx_l) || (ub_q != ub_l) || (lb_q != lb_l);
    assign dat_chg = (dq_q != dat_l);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              latch_en;
    logic              commit;
    logic              rd_done;
    logic              abort;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        commit   = 1'b0;
        rd_done  = 1'b0;
        abort    = 1'b0;

        case (state_q)
            IDLE: begin
                // Write enable wins over output enable.
                if (!cen_q && !wen_q) begin
                    state_d  = WR_WAIT;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end else if (!cen_q && !oen_q) begin
                    state_d  = RD_WAIT;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end
            end

            WR_WAIT: begin
                if (cen_q || wen_q) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (key_chg || dat_chg) begin
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == WR_LAST) begin
                    commit  = 1'b1;
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end

            WR_DONE: begin
                // A still-asserted write whose key or data moves is a new write.
                if (cen_q || wen_q) begin
                    state_d = IDLE;
                end else if (key_chg || dat_chg) begin
                    state_d  = WR_WAIT;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end
            end

            RD_WAIT: begin
                if (cen_q || oen_q) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (!wen_q) begin
                    // Read overtaken by a write: the read counts as dropped.
                    state_d  = WR_WAIT;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                    abort    = 1'b1;
                end else if (key_chg) begin
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == RD_LAST) begin
                    rd_done = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end

            RD_HOLD: begin
                if (cen_q || oen_q) begin
                    state_d = IDLE;
                end else if (!wen_q) begin
                    state_d  = WR_WAIT;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end else if (key_chg) begin
                    state_d  = RD_WAIT;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in1) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_l   <= '0;
            dat_l   <= '0;
            ub_l    <= 1'b1;
            lb_l    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                idx_l <= idx_q;
                dat_l <= dq_q;
                ub_l  <= ub_q;
                lb_l  <= lb_q;
            end
        end
    end

    assign busy = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_dat;
    logic [DATA_W-1:0] rd_keep;

    sram_resp_mem #(
        .DEPTH_LOG2 (IDX_W),
        .LANES      (LANE_W)
    ) u_mem (
        .clk     (clk_in1),
        .wr_en   (commit),
        .wr_idx  (idx_l),
        .wr_mask (lane_mask(ub_l, lb_l)),
        .wr_dat  (dat_l),
        .rd_idx  (idx_l),
        .rd_dat  (rd_dat)
    );

    // Disabled lanes read back as zero.
    assign rd_keep = {{8{~ub_l}}, {8{~lb_l}}};

    // ------------------------------------------------------------------
    // Read data and statistics. ram_dq_o only moves on read completion,
    // which implies cen was low, so it never changes while deselected.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in1) begin
        if (!resetn) begin
            ram_dq_o    <= '0;
            wr_count    <= '0;
            rd_count    <= '0;
            abort_count <= '0;
        end else begin
            if (rd_done) begin
                ram_dq_o <= rd_dat & rd_keep;
                rd_count <= rd_count + CNT_W'(1);
            end
            if (commit) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (abort) begin
                abort_count <= abort_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_if_responder.sv
// Purpose : directed self-checking bench for sram_if_responder.
// Latency : checks read data lands exactly RD_LATENCY+1 edges after capture.
// Backpressure : n/a (bench).
module tb_sram_if_responder;
    import sram_if_pkg::*;

    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;
    localparam int DLOG2  = 10;

    logic        clk_in1;
    logic        resetn;
    logic [26:0] ram_a;
    logic [15:0] ram_dq_i;
    logic [15:0] ram_dq_o;
    logic        ram_cen, ram_oen, ram_wen, ram_ub, ram_lb;
    logic        busy;
    logic [15:0] wr_count, rd_count, abort_count;

    int checks = 0;
    int errors = 0;

    sram_if_responder #(
        .ADDR_W         (27),
        .DATA_W         (16),
        .MEM_DEPTH_LOG2 (DLOG2),
        .RD_LATENCY     (RD_LAT),
        .WR_LATENCY     (WR_LAT)
    ) dut (
        .clk_in1     (clk_in1),
        .resetn      (resetn),
        .ram_a       (ram_a),
        .ram_dq_i    (ram_dq_i),
        .ram_dq_o    (ram_dq_o),
        .ram_cen     (ram_cen),
        .ram_oen     (ram_oen),
        .ram_wen     (ram_wen),
        .ram_ub      (ram_ub),
        .ram_lb      (ram_lb),
        .busy        (busy),
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .abort_count (abort_count)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_in1);
        #1;
    endtask

    task automatic bus_idle();
        ram_cen = 1'b1;
        ram_oen = 1'b1;
        ram_wen = 1'b1;
        ram_ub  = 1'b1;
        ram_lb  = 1'b1;
    endtask

    task automatic write_word(input logic [26:0] a, input logic [15:0] d,
                              input logic ub, input logic lb, input logic oen, input int hold);
        ram_a    = a;
        ram_dq_i = d;
        ram_ub   = ub;
        ram_lb   = lb;
        ram_oen  = oen;
        ram_wen  = 1'b0;
        ram_cen  = 1'b0;
        repeat (hold) tick();
        bus_idle();
        repeat (3) tick();
    endtask

    // Data must still be the previous value one edge before the deadline and
    // the new value exactly RD_LAT+1 edges after the capture edge.
    task automatic read_word(input string tag, input logic [26:0] a, input logic ub, input logic lb,
                             input logic [15:0] prev, input logic [15:0] exp);
        ram_a   = a;
        ram_ub  = ub;
        ram_lb  = lb;
        ram_wen = 1'b1;
        ram_oen = 1'b0;
        ram_cen = 1'b0;
        repeat (RD_LAT + 1) tick();
        check({tag, "_early"}, 32'(ram_dq_o), 32'(prev));
        tick();
        check(tag, 32'(ram_dq_o), 32'(exp));
        repeat (2) tick();
        bus_idle();
        repeat (3) tick();
        check({tag, "_held"}, 32'(ram_dq_o), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn   = 1'b0;
        ram_a    = '0;
        ram_dq_i = '0;
        bus_idle();
        repeat (2) tick();
        check("rst_dq",    32'(ram_dq_o),    32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_wr",    32'(wr_count),    32'h0);
        check("rst_rd",    32'(rd_count),    32'h0);
        check("rst_abort", 32'(abort_count), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        resetn = 1'b1;
        tick();

        // Basic write held 20 cycles, then read back with exact latency.
        ram_a = 27'h200; ram_dq_i = 16'h1236; ram_ub = 1'b0; ram_lb = 1'b0;
        ram_oen = 1'b1; ram_wen = 1'b0; ram_cen = 1'b0;
        repeat (2) tick();
        check("wr_busy", 32'(busy), 32'h1);
        repeat (18) tick();
        check("wr_done_busy", 32'(busy), 32'h0);
        check("wr_cnt1", 32'(wr_count), 32'h1);
        bus_idle();
        repeat (3) tick();
        read_word("rd_1236", 27'h200, 1'b0, 1'b0, 16'h0000, 16'h1236);
        check("rd_cnt1", 32'(rd_count), 32'h1);

        // No lanes enabled: read completes and counts, data is zero.
        read_word("rd_nolane", 27'h200, 1'b1, 1'b1, 16'h1236, 16'h0000);
        check("rd_cnt2", 32'(rd_count), 32'h2);

        // Byte lanes.
        write_word(27'h108, 16'hFFFF, 1'b0, 1'b0, 1'b1, 8);
        write_word(27'h108, 16'h4444, 1'b1, 1'b0, 1'b1, 8);
        check("wr_cnt3", 32'(wr_count), 32'h3);
        read_word("rd_ff44", 27'h108, 1'b0, 1'b0, 16'h0000, 16'hFF44);
        read_word("rd_ff00", 27'h108, 1'b0, 1'b1, 16'hFF44, 16'hFF00);
        check("rd_cnt4", 32'(rd_count), 32'h4);

        // Aborted write: held one cycle short of the latency.
        write_word(27'h200, 16'h5555, 1'b0, 1'b0, 1'b1, WR_LAT - 1);
        check("abort_wr_cnt", 32'(abort_count), 32'h1);
        check("abort_wr_nocommit", 32'(wr_count), 32'h3);

        // Aborted read: output must not move.
        ram_a = 27'h108; ram_ub = 1'b0; ram_lb = 1'b0;
        ram_wen = 1'b1; ram_oen = 1'b0; ram_cen = 1'b0;
        repeat (RD_LAT - 1) tick();
        bus_idle();
        repeat (3) tick();
        check("abort_rd_dq", 32'(ram_dq_o), 32'hFF00);
        check("abort_rd_cnt", 32'(abort_count), 32'h2);
        check("abort_rd_nocount", 32'(rd_count), 32'h4);
        read_word("rd_after_abort", 27'h200, 1'b0, 1'b0, 16'hFF00, 16'h1236);

        // Write dominates output enable; upper address bits alias.
        write_word(27'h088, 16'h2222, 1'b0, 1'b0, 1'b0, 8);
        check("wen_dom_cnt", 32'(wr_count), 32'h4);
        read_word("rd_alias", 27'h088 + (27'd1 << (DLOG2 + 1)), 1'b0, 1'b0, 16'h1236, 16'h2222);
        check("rd_cnt6", 32'(rd_count), 32'h6);

        // Counter wrap: preload the write counter at its top value.
        force dut.wr_count = 16'hFFFF;
        #1;
        release dut.wr_count;
        write_word(27'h300, 16'h3333, 1'b0, 1'b0, 1'b1, 8);
        check("wr_wrap", 32'(wr_count), 32'h0);

        // Reset in the middle of a write: nothing commits, counters clear.
        ram_a = 27'h200; ram_dq_i = 16'h7777; ram_ub = 1'b0; ram_lb = 1'b0;
        ram_oen = 1'b1; ram_wen = 1'b0; ram_cen = 1'b0;
        repeat (3) tick();
        resetn = 1'b0;
        bus_idle();
        repeat (2) tick();
        resetn = 1'b1;
        repeat (2) tick();
        check("midrst_abort", 32'(abort_count), 32'h0);
        check("midrst_wr",    32'(wr_count),    32'h0);
        check("midrst_busy",  32'(busy),        32'h0);
        check("midrst_dq",    32'(ram_dq_o),    32'h0);
        read_word("rd_midrst", 27'h200, 1'b0, 1'b0, 16'h0000, 16'h1236);
        check("midrst_rd", 32'(rd_count), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
